// File: rtl/step_pulse_gen_if.sv
// Key/step bus between the board-side driver and the debounced single-step generator.
// master drives the raw key and count clear; slave returns the step strobe, level and count.
interface step_pulse_gen_if;
    logic        key_in;
    logic        clr_count;
    logic        step;
    logic        key_level;
    logic [15:0] step_count;

    modport master (
        output key_in,
        output clr_count,
        input  step,
        input  key_level,
        input  step_count
    );

    modport slave (
        input  key_in,
        input  clr_count,
        output step,
        output key_level,
        output step_count
    );
endinterface

// File: rtl/step_pulse_gen.sv
// Debounced single-step generator: one clk-wide step per accepted key press plus a 16-bit step count.
// Optional auto-repeat while the key is held is built only when STEP_AUTO_REPEAT_EN is defined.
module step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             resetn,
    step_pulse_gen_if.slave  bus
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        DOWN        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_step;
    logic          r_level;
    logic [15:0]   r_step_count;
    logic          w_cnt_last;
    logic          w_step_nxt;
    logic          w_level_nxt;
    logic          w_rpt_fire;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    // two-flop synchronizer for the asynchronous key
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.key_in;
            r_sync2 <= r_sync1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_sync2) w_state_nxt = ARM_PRESS;
                else         w_state_nxt = IDLE;
            end
            ARM_PRESS: begin
                if (!r_sync2)       w_state_nxt = IDLE;
                else if (w_cnt_last) w_state_nxt = DOWN;
                else                w_state_nxt = ARM_PRESS;
            end
            DOWN: begin
                if (!r_sync2) w_state_nxt = ARM_RELEASE;
                else          w_state_nxt = DOWN;
            end
            ARM_RELEASE: begin
                if (r_sync2)         w_state_nxt = DOWN;
                else if (w_cnt_last) w_state_nxt = IDLE;
                else                 w_state_nxt = ARM_RELEASE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // debounce counter restarts on every state change and only runs in the arming states
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_state_nxt != r_state) begin
            r_cnt <= {CW{1'b0}};
        end else if ((r_state == ARM_PRESS) || (r_state == ARM_RELEASE)) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= {CW{1'b0}};
        end
    end

`ifdef STEP_AUTO_REPEAT_EN
    logic [31:0] r_rpt;
    logic        r_rpt_run;
    logic        w_in_down_stay;

    // first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; any exit from DOWN restarts it
    assign w_in_down_stay = (r_state == DOWN) && (w_state_nxt == DOWN);
    assign w_rpt_fire     = w_in_down_stay &&
                            (r_rpt == (r_rpt_run ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));

    // repeat interval counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rpt     <= 32'd0;
            r_rpt_run <= 1'b0;
        end else if (!w_in_down_stay) begin
            r_rpt     <= 32'd0;
            r_rpt_run <= 1'b0;
        end else if (w_rpt_fire) begin
            r_rpt     <= 32'd0;
            r_rpt_run <= 1'b1;
        end else begin
            r_rpt     <= r_rpt + 32'd1;
            r_rpt_run <= r_rpt_run;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign w_rpt_fire   = 1'b0;
`endif

    // output decode: step on press acceptance (or repeat), level follows accepted transitions
    always_comb begin
        w_step_nxt  = 1'b0;
        w_level_nxt = r_level;
        if ((r_state == ARM_PRESS) && (w_state_nxt == DOWN)) begin
            w_step_nxt  = 1'b1;
            w_level_nxt = 1'b1;
        end else if ((r_state == ARM_RELEASE) && (w_state_nxt == IDLE)) begin
            w_step_nxt  = 1'b0;
            w_level_nxt = 1'b0;
        end else begin
            w_step_nxt  = w_rpt_fire;
            w_level_nxt = r_level;
        end
    end

    // registered strobe and level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_step  <= w_step_nxt;
            r_level <= w_level_nxt;
        end
    end

    // step counter; clear has priority over a coincident step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step_count <= 16'd0;
        end else if (bus.clr_count) begin
            r_step_count <= 16'd0;
        end else if (r_step) begin
            r_step_count <= r_step_count + 16'd1;
        end else begin
            r_step_count <= r_step_count;
        end
    end

    assign bus.step       = r_step;
    assign bus.key_level  = r_level;
    assign bus.step_count = r_step_count;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expected values are hand-derived edge by edge from the first edge that samples the key.
module tb_step_pulse_gen;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    step_pulse_gen_if bus ();

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // key goes high at a negedge; the next posedge is edge 0
    task automatic press_check(input logic [15:0] base);
        logic [15:0] nxt;
        nxt = base + 16'd1;
        bus.key_in = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            chk("press_step",  32'(bus.step),       32'(i == 6));
            chk("press_level", 32'(bus.key_level),  32'(i >= 6));
            chk("press_count", 32'(bus.step_count), (i == 7) ? 32'(nxt) : 32'(base));
        end
    endtask

    task automatic release_check();
        bus.key_in = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            chk("rel_step",  32'(bus.step),      32'd0);
            chk("rel_level", 32'(bus.key_level), 32'(i < 6));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic quiet_check(input int n, input logic lvl, input logic [15:0] cnt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("quiet_step",  32'(bus.step),       32'd0);
            chk("quiet_level", 32'(bus.key_level),  32'(lvl));
            chk("quiet_count", 32'(bus.step_count), 32'(cnt));
        end
    endtask

    initial begin
        logic [15:0] hold_cnt;
        logic        exp_step;
        n_checks      = 0;
        n_errors      = 0;
        resetn        = 1'b0;
        bus.key_in    = 1'b0;
        bus.clr_count = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step",  32'(bus.step),       32'd0);
        chk("rst_level", 32'(bus.key_level),  32'd0);
        chk("rst_count", 32'(bus.step_count), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // clean press and release
        press_check(16'd0);
        release_check();

        // bounce: high 3, low 1, high 2, then low
        bus.key_in = 1'b1; repeat (3) @(negedge clk);
        bus.key_in = 1'b0; @(negedge clk);
        bus.key_in = 1'b1; repeat (2) @(negedge clk);
        bus.key_in = 1'b0;
        quiet_check(12, 1'b0, 16'd1);

        // release bounce: drop 2 cycles while accepted, then hold again
        press_check(16'd1);
        bus.key_in = 1'b0; repeat (2) @(negedge clk);
        bus.key_in = 1'b1;
        quiet_check(12, 1'b1, 16'd2);
        release_check();

        // wrap from 0xFFFF
        force dut.r_step_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_step_count;
        @(negedge clk);
        chk("wrap_preload", 32'(bus.step_count), 32'h0000_FFFF);
        press_check(16'hFFFF);
        release_check();

        // clear coincident with a step
        press_check(16'd0);
        release_check();
        bus.key_in = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                chk("clr_step", 32'(bus.step), 32'd1);
                bus.clr_count = 1'b1;
            end else if (i == 7) begin
                bus.clr_count = 1'b0;
                chk("clr_count", 32'(bus.step_count), 32'd0);
            end else begin
                chk("clr_pre", 32'(bus.step_count), 32'd1);
            end
        end
        release_check();

        // reset while arming with cnt=2 (after edge 4), key kept held
        press_check(16'd0);
        release_check();
        bus.key_in = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_step",  32'(bus.step),       32'd0);
        chk("mid_rst_level", 32'(bus.key_level),  32'd0);
        chk("mid_rst_count", 32'(bus.step_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        press_check(16'd0);
        release_check();

        // long hold: single step, or auto-repeat at +10 then every 3
        bus.key_in = 1'b1;
        hold_cnt   = 16'd1;
        for (int i = 0; i <= 37; i++) begin
            @(negedge clk);
`ifdef STEP_AUTO_REPEAT_EN
            exp_step = (i == 6) || ((i >= 16) && (((i - 16) % 3) == 0));
`else
            exp_step = (i == 6);
`endif
            chk("hold_step", 32'(bus.step), 32'(exp_step));
            if (exp_step) hold_cnt = hold_cnt + 16'd1;
        end
        release_check();
        chk("hold_count", 32'(bus.step_count), 32'(hold_cnt));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
